// File: rtl/wakeup_port_arbiter.sv
// Shares N_PORT registered wakeup/writeback ports among N_REQ requesters through small
// per-requester FIFOs, granting queue heads round-robin and squashing entries younger than a redirect.
module wakeup_port_arbiter #(
  parameter int N_REQ  = 6,
  parameter int N_PORT = 4,
  parameter int DEPTH  = 2,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_valid,
  output logic [N_REQ-1:0]                     req_ready,
  input  logic [N_REQ-1:0]                     req_we,
  input  logic [N_REQ*PREG_W-1:0]              req_prd,
  input  logic [N_REQ*(ROB_W+1)-1:0]           req_rob,
  input  logic                                 redirect_valid,
  input  logic [ROB_W:0]                       redirect_rob,
  output logic [N_PORT-1:0]                    wb_en,
  output logic [N_PORT-1:0]                    wb_we,
  output logic [N_PORT*PREG_W-1:0]             wb_rd,
  output logic [N_PORT*(ROB_W+1)-1:0]          wb_rob,
  output logic [$clog2(N_REQ*DEPTH+1)-1:0]     pending
);

  localparam int TAG_W  = ROB_W + 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PEND_W = $clog2(N_REQ * DEPTH + 1);
  localparam int RR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Each FIFO is kept as an ordered array: slot 0 is always the head.
  logic [PREG_W-1:0]        prd_q [N_REQ][DEPTH];
  logic [PREG_W-1:0]        prd_d [N_REQ][DEPTH];
  logic [TAG_W-1:0]         rob_q [N_REQ][DEPTH];
  logic [TAG_W-1:0]         rob_d [N_REQ][DEPTH];
  logic [CNT_W-1:0]         cnt_q [N_REQ];
  logic [CNT_W-1:0]         cnt_d [N_REQ];
  logic [RR_W-1:0]          rr_q, rr_d;
  logic [N_REQ-1:0]         elig;
  logic [N_REQ-1:0]         pop;
  logic [N_PORT-1:0]        wb_en_q, wb_en_d;
  logic [N_PORT*PREG_W-1:0] wb_rd_q, wb_rd_d;
  logic [N_PORT*TAG_W-1:0]  wb_rob_q, wb_rob_d;
  logic [PEND_W-1:0]        pending_q, pending_d;

  // Age compare with wrap bit; equal tags are not younger.
  function automatic logic is_younger(input logic [TAG_W-1:0] e, input logic [TAG_W-1:0] r);
    if (e[ROB_W] == r[ROB_W]) begin
      return e[ROB_W-1:0] > r[ROB_W-1:0];
    end else begin
      return e[ROB_W-1:0] < r[ROB_W-1:0];
    end
  endfunction

  // Ready and head eligibility from registered occupancy only.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (cnt_q[i] < DEPTH_C);
      elig[i]      = (cnt_q[i] != '0) &&
                     !(redirect_valid && is_younger(rob_q[i][0], redirect_rob));
    end
  end

  // Round-robin scan starting at rr_q; the k-th eligible head takes port k.
  always_comb begin
    int k;
    int idx;
    k        = 0;
    idx      = 0;
    pop      = '0;
    rr_d     = rr_q;
    wb_en_d  = '0;
    wb_rd_d  = '0;
    wb_rob_d = '0;
    for (int s = 0; s < N_REQ; s++) begin
      idx = (int'(rr_q) + s) % N_REQ;
      if (elig[idx] && (k < N_PORT)) begin
        pop[idx]                    = 1'b1;
        wb_en_d[k]                  = 1'b1;
        wb_rd_d[k*PREG_W +: PREG_W] = prd_q[idx][0];
        wb_rob_d[k*TAG_W +: TAG_W]  = rob_q[idx][0];
        rr_d                        = RR_W'((idx + 1) % N_REQ);
        k                           = k + 1;
      end else begin
        k = k;
      end
    end
  end

  // FIFO next state: drop the popped head and squashed entries, compact, then append the filtered arrival.
  always_comb begin
    int   k;
    logic keep;
    logic push;
    prd_d     = prd_q;
    rob_d     = rob_q;
    pending_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = 0;
      for (int j = 0; j < DEPTH; j++) begin
        keep = (CNT_W'(j) < cnt_q[i]) && !((j == 0) && pop[i]) &&
               !(redirect_valid && is_younger(rob_q[i][j], redirect_rob));
        if (keep) begin
          prd_d[i][k] = prd_q[i][j];
          rob_d[i][k] = rob_q[i][j];
          k           = k + 1;
        end else begin
          k = k;
        end
      end
      push = req_valid[i] && req_ready[i] && req_we[i] &&
             !(redirect_valid && is_younger(req_rob[i*TAG_W +: TAG_W], redirect_rob));
      if (push && (k < DEPTH)) begin
        prd_d[i][k] = req_prd[i*PREG_W +: PREG_W];
        rob_d[i][k] = req_rob[i*TAG_W +: TAG_W];
        k           = k + 1;
      end else begin
        k = k;
      end
      cnt_d[i]  = CNT_W'(k);
      pending_d = pending_d + PEND_W'(cnt_d[i]);
    end
  end

  // State and output registers; the wakeup register is reloaded every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          prd_q[i][j] <= '0;
          rob_q[i][j] <= '0;
        end
      end
      rr_q      <= '0;
      wb_en_q   <= '0;
      wb_rd_q   <= '0;
      wb_rob_q  <= '0;
      pending_q <= '0;
    end else begin
      prd_q     <= prd_d;
      rob_q     <= rob_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_rob_q  <= wb_rob_d;
      pending_q <= pending_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_we   = wb_en_q;
  assign wb_rd   = wb_rd_q;
  assign wb_rob  = wb_rob_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_wakeup_port_arbiter.sv
// Directed bench for wakeup_port_arbiter: stimulus pushes expected (prd, rob) per requester into
// scoreboard queues; a negedge monitor pops and compares every wakeup the DUT presents.
module tb_wakeup_port_arbiter;
  localparam int N_REQ  = 6;
  localparam int N_PORT = 4;
  localparam int DEPTH  = 2;
  localparam int PREG_W = 7;
  localparam int ROB_W  = 6;
  localparam int TAG_W  = ROB_W + 1;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ-1:0]           req_we;
  logic [N_REQ*PREG_W-1:0]    req_prd;
  logic [N_REQ*TAG_W-1:0]     req_rob;
  logic                       redirect_valid;
  logic [TAG_W-1:0]           redirect_rob;
  logic [N_PORT-1:0]          wb_en;
  logic [N_PORT-1:0]          wb_we;
  logic [N_PORT*PREG_W-1:0]   wb_rd;
  logic [N_PORT*TAG_W-1:0]    wb_rob;
  logic [3:0]                 pending;

  // prd[6:4] carries the requester id so the monitor can route each wakeup to its queue.
  logic [13:0] sbq [N_REQ][$];
  int n_vec = 0;
  int n_err = 0;
  int exp_a [4] = '{0, 1, 2, 3};
  int exp_b [4] = '{4, 5, 0, 1};

  always #5 clk = ~clk;

  wakeup_port_arbiter #(
    .N_REQ(N_REQ), .N_PORT(N_PORT), .DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_prd(req_prd), .req_rob(req_rob),
    .redirect_valid(redirect_valid), .redirect_rob(redirect_rob),
    .wb_en(wb_en), .wb_we(wb_we), .wb_rd(wb_rd), .wb_rob(wb_rob),
    .pending(pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] rd_at(input int p);
    return wb_rd[p*PREG_W +: PREG_W];
  endfunction

  function automatic logic [6:0] rob_at(input int p);
    return wb_rob[p*TAG_W +: TAG_W];
  endfunction

  function automatic int sb_total();
    int t = 0;
    for (int r = 0; r < N_REQ; r++) t += sbq[r].size();
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid      = '0;
    req_we         = '0;
    req_prd        = '0;
    req_rob        = '0;
    redirect_valid = 1'b0;
    redirect_rob   = '0;
  endtask

  task automatic put(input int r, input logic [6:0] prd, input logic [6:0] rob,
                     input logic we, input logic expect_q);
    req_valid[r]                = 1'b1;
    req_we[r]                   = we;
    req_prd[r*PREG_W +: PREG_W] = prd;
    req_rob[r*TAG_W +: TAG_W]   = rob;
    if (expect_q) sbq[r].push_back({prd, rob});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (sb_total() > 0 && cyc < 50) begin
      step();
      cyc++;
    end
    chk(name, sb_total(), 0);
  endtask

  task automatic chk_ids(input string name, input int ids [4]);
    for (int p = 0; p < N_PORT; p++)
      chk($sformatf("%s id%0d", name, p), {29'd0, rd_at(p)[6:4]}, ids[p]);
  endtask

  // Monitor: every presented wakeup must match the head of its requester's expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < N_PORT; p++) begin
        if (wb_en[p]) begin
          logic [6:0]  rd;
          logic [6:0]  rb;
          logic [13:0] e;
          int          id;
          rd = rd_at(p);
          rb = rob_at(p);
          id = int'(rd[6:4]);
          chk($sformatf("wb_we%0d", p), wb_we[p], 1);
          if (id >= N_REQ || sbq[id].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_wb: port %0d rd 0x%0h rob 0x%0h, nothing expected", p, rd, rb);
          end else begin
            e = sbq[id].pop_front();
            chk($sformatf("sb rd req%0d", id), rd, e[13:7]);
            chk($sformatf("sb rob req%0d", id), rb, e[6:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_req();
    repeat (2) @(posedge clk);
    #1;
    chk("reset wb_en", wb_en, 0);
    chk("reset pending", pending, 0);
    chk("reset ready", req_ready, 6'h3f);
    chk("reset wb_rd", wb_rd, 0);
    chk("reset wb_rob", wb_rob, 0);
    rst = 1'b0;
    step();

    // Reset mid-run with five entries queued: nothing may ever emerge.
    for (int r = 0; r < 5; r++) put(r, 7'(r * 16 + 7), 7'(r + 1), 1'b1, 1'b0);
    step();
    clear_req();
    chk("t1 pending", pending, 5);
    rst = 1'b1;
    #1;
    chk("t1 wb_en", wb_en, 0);
    chk("t1 pending rst", pending, 0);
    chk("t1 ready", req_ready, 6'h3f);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("t1 pending after", pending, 0);

    // Oversubscription from rr_ptr=0, with req0/req1 refilled.
    for (int r = 0; r < N_REQ; r++) put(r, 7'(r * 16), 7'(r + 1), 1'b1, 1'b1);
    step();
    clear_req();
    chk("t3 pending0", pending, 6);
    chk("t3 wb_en0", wb_en, 0);
    put(0, 7'h01, 7'd11, 1'b1, 1'b1);
    put(1, 7'h11, 7'd12, 1'b1, 1'b1);
    step();
    clear_req();
    chk("t3 wb_en_a", wb_en, 4'hf);
    chk_ids("t3a", exp_a);
    chk("t3 pending_a", pending, 4);
    step();
    chk("t3 wb_en_b", wb_en, 4'hf);
    chk_ids("t3b", exp_b);
    chk("t3 pending_b", pending, 0);
    step();
    chk("t3 wb_en_idle", wb_en, 0);

    // Single request: two-cycle latency, one cycle of wb_en.
    put(0, 7'd12, 7'd3, 1'b1, 1'b1);
    step();
    clear_req();
    chk("t2 wb_en T+1", wb_en, 0);
    chk("t2 pending T+1", pending, 1);
    step();
    chk("t2 wb_en T+2", wb_en, 4'b0001);
    chk("t2 rd0", rd_at(0), 7'd12);
    chk("t2 rob0", rob_at(0), 7'd3);
    chk("t2 pending T+2", pending, 0);
    step();
    chk("t2 wb_en T+3", wb_en, 0);
    wait_drain("t2 drain");

    // Backpressure on req2 while req4,5,0,1 hold all ports (rr_ptr steered to 4 via req3).
    do_reset();
    put(3, 7'h30, 7'd20, 1'b1, 1'b1);
    step();
    clear_req();
    step();
    step();
    put(4, 7'h42, 7'd34, 1'b1, 1'b1);
    put(5, 7'h52, 7'd35, 1'b1, 1'b1);
    put(0, 7'h02, 7'd30, 1'b1, 1'b1);
    put(1, 7'h12, 7'd31, 1'b1, 1'b1);
    put(2, 7'h20, 7'd40, 1'b1, 1'b1);
    step();
    clear_req();
    chk("t4 ready2 one", req_ready[2], 1);
    put(2, 7'h21, 7'd41, 1'b1, 1'b1);
    step();
    clear_req();
    chk("t4 wb_en sat", wb_en, 4'hf);
    chk_ids("t4", exp_b);
    chk("t4 ready2 full", req_ready[2], 0);
    chk("t4 pending full", pending, 2);
    put(2, 7'h22, 7'd42, 1'b1, 1'b1);
    step();
    chk("t4 wb_en held", wb_en, 4'b0001);
    chk("t4 rd held", rd_at(0), 7'h20);
    chk("t4 ready2 freed", req_ready[2], 1);
    chk("t4 pending held", pending, 1);
    step();
    clear_req();
    chk("t4 rd second", rd_at(0), 7'h21);
    chk("t4 pending second", pending, 1);
    step();
    chk("t4 rd third", rd_at(0), 7'h22);
    chk("t4 pending third", pending, 0);
    wait_drain("t4 drain");

    // Redirect at rob 7 while req2/req3 wait behind saturated ports; same-cycle young and we=0 arrivals.
    do_reset();
    put(3, 7'h30, 7'd20, 1'b1, 1'b1);
    step();
    clear_req();
    step();
    step();
    put(4, 7'h43, 7'd1, 1'b1, 1'b1);
    put(5, 7'h53, 7'd2, 1'b1, 1'b1);
    put(0, 7'h03, 7'd3, 1'b1, 1'b1);
    put(1, 7'h13, 7'h4a, 1'b1, 1'b1);
    put(2, 7'h23, 7'd5, 1'b1, 1'b1);
    put(3, 7'h33, 7'd9, 1'b1, 1'b0);
    step();
    clear_req();
    chk("t5 pending pre", pending, 6);
    redirect_valid = 1'b1;
    redirect_rob   = 7'd7;
    put(3, 7'h34, 7'h0c, 1'b1, 1'b0);
    put(5, 7'h54, 7'd1, 1'b0, 1'b0);
    chk("t6 ready3", req_ready[3], 1);
    chk("t6 ready5", req_ready[5], 1);
    step();
    clear_req();
    chk("t5 wb_en", wb_en, 4'hf);
    chk_ids("t5", exp_b);
    chk("t5 rob wrap", rob_at(3), 7'h4a);
    chk("t5 pending post", pending, 1);
    step();
    chk("t5 wb_en surv", wb_en, 4'b0001);
    chk("t5 rob surv", rob_at(0), 7'd5);
    chk("t5 pending end", pending, 0);
    step();
    chk("t5 wb_en idle", wb_en, 0);

    // Lone we=0 request: consumed, never queued.
    put(1, 7'h15, 7'd2, 1'b0, 1'b0);
    step();
    clear_req();
    chk("t6 pending", pending, 0);
    step();
    chk("t6 wb_en", wb_en, 0);
    chk("t6 ready", req_ready, 6'h3f);

    // Redirect with wrap bit set: older (0x05), equal (0x42) survive; 0x43 and 0x01 are younger.
    redirect_valid = 1'b1;
    redirect_rob   = 7'h42;
    put(0, 7'h05, 7'h05, 1'b1, 1'b1);
    put(1, 7'h16, 7'h43, 1'b1, 1'b0);
    put(2, 7'h27, 7'h42, 1'b1, 1'b1);
    put(3, 7'h38, 7'h01, 1'b1, 1'b0);
    step();
    clear_req();
    chk("t7 pending", pending, 2);
    step();
    chk("t7 wb_en", wb_en, 4'b0011);
    wait_drain("final drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
